core_mmio_timer: RTL and testbench

CORE_MMIO_TIMER -- requirements
Module: core_mmio_timer

---
 rtl/core_common.svh | 9 +
 rtl/core_mmio_timer.sv | 134 +++++++++++++
 tb/tb_core_mmio_timer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/core_common.svh
// Register map shared by core blocks: timer register offsets, ctrl field layout, window size.
// Included inside module bodies so the names stay local to each including module.
localparam logic [4:0]  TIM_OFF_MTIME    = 5'h00;
localparam logic [4:0]  TIM_OFF_MTIMECMP = 5'h08;
localparam logic [4:0]  TIM_OFF_CTRL     = 5'h10;
localparam int unsigned TIM_WIN_BYTES    = 32;
localparam int unsigned TIM_CTRL_EN_BIT  = 0;
localparam int unsigned TIM_CTRL_DIV_LSB = 8;
localparam int unsigned TIM_CTRL_DIV_W   = 8;

// File: rtl/core_mmio_timer.sv
// Memory-mapped machine timer (mtime/mtimecmp/ctrl) on a zero-wait-state dmem port.
// Define TIMER_PRESCALE_EN to enable the 8-bit tick prescaler controlled by ctrl.DIV.
module core_mmio_timer #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        dmem_req,
  input  logic [63:0] dmem_addr,
  input  logic        dmem_wen,
  input  logic [7:0]  dmem_strb,
  input  logic [63:0] dmem_wdata,
  output logic        dmem_gnt,
  output logic        dmem_err,
  output logic [63:0] dmem_rdata,
  output logic        tim_int
);
  `include "core_common.svh"

  function automatic logic [63:0] strb_merge(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  strb);
    logic [63:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++)
      if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    return r;
  endfunction

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        en_q, en_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        tim_int_q, tim_int_d;
`ifdef TIMER_PRESCALE_EN
  logic [TIM_CTRL_DIV_W-1:0] div_q, div_d;
  logic [TIM_CTRL_DIV_W-1:0] pscnt_q, pscnt_d;
`endif

  logic [63:0] off;
  logic        win_hit, sel_mtime, sel_cmp, sel_ctrl, acc_ok, ctrl_wr, tick;
  logic [63:0] ctrl_rd, rd_mux;

  assign dmem_gnt   = dmem_req;
  assign dmem_err   = err_q;
  assign dmem_rdata = rdata_q;
  assign tim_int    = tim_int_q;

  always_comb begin
    off       = dmem_addr - BASE_ADDR;
    win_hit   = (dmem_addr >= BASE_ADDR) && (off < 64'(TIM_WIN_BYTES));
    // Exact 5-bit offset match also rejects misaligned addresses.
    sel_mtime = win_hit && (off[4:0] == TIM_OFF_MTIME);
    sel_cmp   = win_hit && (off[4:0] == TIM_OFF_MTIMECMP);
    sel_ctrl  = win_hit && (off[4:0] == TIM_OFF_CTRL);
    acc_ok    = sel_mtime || sel_cmp || sel_ctrl;
    ctrl_wr   = dmem_req && dmem_wen && sel_ctrl;

    ctrl_rd = '0;
    ctrl_rd[TIM_CTRL_EN_BIT] = en_q;
`ifdef TIMER_PRESCALE_EN
    ctrl_rd[TIM_CTRL_DIV_LSB +: TIM_CTRL_DIV_W] = div_q;
    tick = en_q && (pscnt_q == div_q);
`else
    // No prescaler: DIV is not stored and reads back as zero.
    ctrl_rd[TIM_CTRL_DIV_LSB +: TIM_CTRL_DIV_W] = '0;
    tick = en_q;
`endif

    rd_mux = sel_mtime ? mtime_q : sel_cmp ? mtimecmp_q : ctrl_rd;

    mtime_d    = mtime_q + 64'(tick);
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
`ifdef TIMER_PRESCALE_EN
    div_d      = div_q;
`endif

    if (dmem_req) begin
      err_d   = !acc_ok;
      rdata_d = '0;
      if (acc_ok) begin
        if (!dmem_wen) begin
          rdata_d = rd_mux;
        end else begin
          // A bus write to mtime overrides the same-cycle tick.
          if (sel_mtime) mtime_d    = strb_merge(mtime_q, dmem_wdata, dmem_strb);
          if (sel_cmp)   mtimecmp_d = strb_merge(mtimecmp_q, dmem_wdata, dmem_strb);
          if (ctrl_wr && dmem_strb[TIM_CTRL_EN_BIT/8])
            en_d = dmem_wdata[TIM_CTRL_EN_BIT];
`ifdef TIMER_PRESCALE_EN
          if (ctrl_wr && dmem_strb[TIM_CTRL_DIV_LSB/8])
            div_d = dmem_wdata[TIM_CTRL_DIV_LSB +: TIM_CTRL_DIV_W];
`endif
        end
      end
    end

`ifdef TIMER_PRESCALE_EN
    pscnt_d = (ctrl_wr || !en_q || tick) ? '0 : pscnt_q + 1'b1;
`endif
    tim_int_d = (mtime_d >= mtimecmp_d);
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      en_q       <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      tim_int_q  <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      div_q      <= '0;
      pscnt_q    <= '0;
`endif
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      tim_int_q  <= tim_int_d;
`ifdef TIMER_PRESCALE_EN
      div_q      <= div_d;
      pscnt_q    <= pscnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_core_mmio_timer.sv
// Scoreboard bench for core_mmio_timer: driver queues expected responses, monitor pops and compares.
module tb_core_mmio_timer;
  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef TIMER_PRESCALE_EN
  localparam logic [63:0] CTRL_ALL = 64'h0000_0000_0000_FF01;
  localparam logic [63:0] CTRL_DIV = 64'h0000_0000_0000_0300;
  localparam logic [63:0] CTRL_RUN = 64'h0000_0000_0000_0301;
  localparam logic [63:0] RUN40    = 64'd10;
`else
  localparam logic [63:0] CTRL_ALL = 64'h1;
  localparam logic [63:0] CTRL_DIV = 64'h0;
  localparam logic [63:0] CTRL_RUN = 64'h1;
  localparam logic [63:0] RUN40    = 64'd40;
`endif

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b1;
  logic        dmem_req = 1'b0;
  logic [63:0] dmem_addr = '0;
  logic        dmem_wen = 1'b0;
  logic [7:0]  dmem_strb = '0;
  logic [63:0] dmem_wdata = '0;
  logic        dmem_gnt, dmem_err, tim_int;
  logic [63:0] dmem_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [63:0] rd;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  core_mmio_timer #(.BASE_ADDR(BASE)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
    .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .tim_int(tim_int)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge g_clk);
    #1;
  endtask

  // Presents one request for one cycle; the response is checked by the monitor.
  task automatic xfer(input string name, input logic [63:0] addr, input logic wen,
                      input logic [7:0] strb, input logic [63:0] wd,
                      input logic [63:0] exp_rd, input logic exp_err);
    exp_t e;
    dmem_req = 1'b1; dmem_addr = addr; dmem_wen = wen; dmem_strb = strb; dmem_wdata = wd;
    e.name = name; e.rd = exp_rd; e.err = exp_err;
    exp_q.push_back(e);
    #1 chk({name, " gnt"}, 64'(dmem_gnt), 64'd1);
    @(posedge g_clk);
    #1;
    dmem_req = 1'b0; dmem_wen = 1'b0; dmem_strb = '0;
  endtask

  task automatic wr(input string name, input logic [4:0] off, input logic [63:0] wd);
    xfer(name, BASE + 64'(off), 1'b1, 8'hFF, wd, 64'd0, 1'b0);
  endtask

  task automatic rd(input string name, input logic [4:0] off, input logic [63:0] exp);
    xfer(name, BASE + 64'(off), 1'b0, 8'h00, 64'd0, exp, 1'b0);
  endtask

  // Monitor: every granted request outside reset yields exactly one response next cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge g_clk);
      if (g_resetn && dmem_req) begin
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got rdata %h err %0d, expected no response", dmem_rdata, dmem_err);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, " rdata"}, dmem_rdata, e.rd);
          chk({e.name, " err"}, 64'(dmem_err), 64'(e.err));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 g_resetn = 1'b0;
    #1;
    chk("rst rdata", dmem_rdata, 64'd0);
    chk("rst err", 64'(dmem_err), 64'd0);
    chk("rst tim_int", 64'(tim_int), 64'd0);
    chk("idle gnt", 64'(dmem_gnt), 64'd0);
    dmem_req = 1'b1;
    #1 chk("gnt in reset", 64'(dmem_gnt), 64'd1);
    dmem_req = 1'b0;
    wait_cyc(2);
    g_resetn = 1'b1;
    rd("rst mtimecmp", 5'h08, ONES);

    // Free-running count with every-cycle tick.
    wr("ctrl en", 5'h10, 64'h1);
    wait_cyc(10);
    rd("mtime after 10", 5'h00, 64'd10);

    // Compare hit timing.
    wr("cmp 20", 5'h08, 64'd20);
    wr("mtime 15", 5'h00, 64'd15);
    chk("tim_int after mtime wr", 64'(tim_int), 64'd0);
    wait_cyc(4);
    chk("tim_int at 19", 64'(tim_int), 64'd0);
    wait_cyc(1);
    chk("tim_int at 20", 64'(tim_int), 64'd1);
    wr("cmp 100", 5'h08, 64'd100);
    chk("tim_int after cmp 100", 64'(tim_int), 64'd0);

    // Wrap around 2^64.
    wr("cmp max", 5'h08, ONES);
    wr("mtime max-1", 5'h00, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("tim_int max-1", 64'(tim_int), 64'd0);
    wait_cyc(1);
    chk("tim_int max", 64'(tim_int), 64'd1);
    wait_cyc(1);
    chk("tim_int wrapped", 64'(tim_int), 64'd0);
    rd("mtime wrapped", 5'h00, 64'd0);

    // Error decode leaves state untouched.
    wr("ctrl off", 5'h10, 64'h0);
    wr("mtime 1234", 5'h00, 64'h1234);
    wr("cmp 5678", 5'h08, 64'h5678);
    xfer("rd off18", BASE + 64'h18, 1'b0, 8'h00, 64'd0, 64'd0, 1'b1);
    xfer("rd base+4", BASE + 64'h04, 1'b0, 8'h00, 64'd0, 64'd0, 1'b1);
    xfer("rd base+40", BASE + 64'h40, 1'b0, 8'h00, 64'd0, 64'd0, 1'b1);
    xfer("rd below base", BASE - 64'h8, 1'b0, 8'h00, 64'd0, 64'd0, 1'b1);
    xfer("wr base+4", BASE + 64'h04, 1'b1, 8'hFF, ONES, 64'd0, 1'b1);
    xfer("wr base+20", BASE + 64'h20, 1'b1, 8'hFF, ONES, 64'd0, 1'b1);
    xfer("wr off18", BASE + 64'h18, 1'b1, 8'hFF, ONES, 64'd0, 1'b1);
    xfer("wr base+14", BASE + 64'h14, 1'b1, 8'hFF, ONES, 64'd0, 1'b1);
    rd("mtime kept", 5'h00, 64'h1234);
    rd("cmp kept", 5'h08, 64'h5678);
    rd("ctrl kept", 5'h10, 64'h0);
    chk("tim_int kept", 64'(tim_int), 64'd0);

    // Byte strobes.
    wr("mtime 0", 5'h00, 64'd0);
    xfer("mtime strb0F", BASE, 1'b1, 8'h0F, ONES, 64'd0, 1'b0);
    rd("mtime merged", 5'h00, 64'h0000_0000_FFFF_FFFF);
    xfer("cmp strb81", BASE + 64'h08, 1'b1, 8'h81, 64'hAABB_CCDD_EEFF_0011, 64'd0, 1'b0);
    rd("cmp merged", 5'h08, 64'hAA00_0000_0000_5611);
    wr("ctrl all", 5'h10, ONES);
    rd("ctrl fields", 5'h10, CTRL_ALL);
    wr("ctrl clr", 5'h10, 64'h0);
    xfer("ctrl div only", BASE + 64'h10, 1'b1, 8'h02, 64'h0000_0000_0000_0300, 64'd0, 1'b0);
    rd("ctrl div", 5'h10, CTRL_DIV);

    // Prescaled run (DIV=3 when the prescaler is built, every cycle otherwise).
    wr("mtime 0 b", 5'h00, 64'd0);
    wr("ctrl run", 5'h10, 64'h301);
    wait_cyc(40);
    rd("mtime after 40", 5'h00, RUN40);

    // Asynchronous reset mid-run with a request in flight.
    wr("cmp 0", 5'h08, 64'd0);
    rd("ctrl run rd", 5'h10, CTRL_RUN);
    chk("tim_int cmp 0", 64'(tim_int), 64'd1);
    dmem_req = 1'b1; dmem_addr = BASE; dmem_wen = 1'b0;
    #2 g_resetn = 1'b0;
    #1;
    chk("async rst rdata", dmem_rdata, 64'd0);
    chk("async rst tim_int", 64'(tim_int), 64'd0);
    chk("async rst err", 64'(dmem_err), 64'd0);
    chk("async rst gnt", 64'(dmem_gnt), 64'd1);
    dmem_req = 1'b0;
    wait_cyc(2);
    g_resetn = 1'b1;
    xfer("rd off18 b", BASE + 64'h18, 1'b0, 8'h00, 64'd0, 64'd0, 1'b1);
    #2 g_resetn = 1'b0;
    #1 chk("async rst err b", 64'(dmem_err), 64'd0);
    wait_cyc(2);
    g_resetn = 1'b1;
    rd("post rst mtime", 5'h00, 64'd0);
    rd("post rst cmp", 5'h08, ONES);
    rd("post rst ctrl", 5'h10, 64'd0);
    chk("post rst tim_int", 64'(tim_int), 64'd0);

    wait_cyc(2);
    chk("queue drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
